// File: rtl/load_store_unit_if.sv
// Shared ISA types and the core/memory port bundle of the load/store unit.
// The unit side takes the slave modport; the core plus memory side takes master.
package isa_types;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    write_byte,
    write_halfword,
    write_word
  } write_width_t;
endpackage

interface load_store_unit_if;
  import isa_types::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic [1:0]      resp_fault;
  logic [XLEN-1:0] mem_addr;
  write_width_t    mem_wwidth;
  logic            mem_wenable;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3,
    input  req_addr, req_wdata, resp_ready,
    input  mem_rdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_fault,
    output mem_addr, mem_wwidth,
    output mem_wenable, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3,
    output req_addr, req_wdata, resp_ready,
    output mem_rdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_fault,
    input  mem_addr, mem_wwidth,
    input  mem_wenable, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: checks one request at a time, drives the data
// memory port and returns extended load data or a fault code.
module load_store_unit
  import isa_types::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input logic              clock,
  input logic              reset_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    LOAD_CAPTURE,
    RESP
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            store_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] rdata_q;
  logic [1:0]      fault_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  write_width_t    wwidth_q;

  logic            accept;
  logic            illegal_c;
  logic            misalign_c;
  logic            range_c;
  logic [1:0]      fault_c;
  logic [XLEN:0]   size_m1_c;
  logic [XLEN:0]   last_c;
  write_width_t    wwidth_c;
  logic [XLEN-1:0] ext_c;

  logic [2:0]      f3;
  logic [XLEN-1:0] a;

  assign f3 = bus.req_funct3;
  assign a  = bus.req_addr;

  assign accept = (state_q == IDLE) && bus.req_valid;

  assign illegal_c = (f3[1:0] == 2'b11)
                   || (f3[2] && (f3[1] || bus.req_store));

  assign misalign_c = ((f3[1:0] == 2'b01) && a[0])
                    || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));

  assign size_m1_c = (f3[1:0] == 2'b00) ? (XLEN+1)'(0) :
                     (f3[1:0] == 2'b01) ? (XLEN+1)'(1) :
                                          (XLEN+1)'(3);

  // One extra bit so an access wrapping past 2^XLEN still faults.
  assign last_c  = {1'b0, a} + size_m1_c;
  assign range_c = last_c >= (XLEN+1)'(MEM_BYTES);

  always_comb begin
    fault_c = 2'b00;
    if (illegal_c)       fault_c = 2'b11;
    else if (misalign_c) fault_c = 2'b01;
    else if (range_c)    fault_c = 2'b10;
  end

  always_comb begin
    wwidth_c = write_word;
    unique case (f3[1:0])
      2'b00:   wwidth_c = write_byte;
      2'b01:   wwidth_c = write_halfword;
      default: wwidth_c = write_word;
    endcase
  end

  always_comb begin
    ext_c = bus.mem_rdata;
    unique case (funct3_q)
      3'b000:  ext_c = {{(XLEN-8){bus.mem_rdata[7]}},
                        bus.mem_rdata[7:0]};
      3'b100:  ext_c = {{(XLEN-8){1'b0}},
                        bus.mem_rdata[7:0]};
      3'b001:  ext_c = {{(XLEN-16){bus.mem_rdata[15]}},
                        bus.mem_rdata[15:0]};
      3'b101:  ext_c = {{(XLEN-16){1'b0}},
                        bus.mem_rdata[15:0]};
      default: ext_c = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid)
          state_d = (fault_c != 2'b00) ? RESP : ACCESS;
      end
      ACCESS:       state_d = store_q ? RESP : LOAD_CAPTURE;
      LOAD_CAPTURE: state_d = RESP;
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      rdata_q  <= '0;
      fault_q  <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      wwidth_q <= write_word;
    end else begin
      state_q <= state_d;
      if (accept) begin
        store_q  <= bus.req_store;
        funct3_q <= f3;
        fault_q  <= fault_c;
        rdata_q  <= '0;
        // Faulting requests never reach memory, so the port keeps its values.
        if (fault_c == 2'b00) begin
          addr_q   <= a;
          wdata_q  <= bus.req_wdata;
          wwidth_q <= wwidth_c;
        end
      end
      if (state_q == LOAD_CAPTURE) rdata_q <= ext_c;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.resp_valid  = (state_q == RESP);
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_fault  = fault_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_wwidth  = wwidth_q;
  assign bus.mem_wenable = (state_q == ACCESS) && store_q && reset_n;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte memory device, reference model
// of requests, per-cycle compare process, directed and random traffic.
module tb_load_store_unit;
  import isa_types::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  load_store_unit_if bus();

  load_store_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] dmem [1024] = '{default: 8'h00};
  logic [7:0] ref_mem [1024] = '{default: 8'h00};

  typedef struct {
    logic [1:0]  fault;
    logic [31:0] rdata;
    int          lat;
    bit          commit;
  } exp_t;

  exp_t        cur;
  bit          busy = 0;
  bit          hs_pend = 0;
  bit          chk_on = 0;
  int          n = 0;
  int          rv_cycles = 0;
  logic [31:0] last_rdata = '0;
  logic [1:0]  last_fault = '0;

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Data memory device: lanes shifted here, read data one cycle late.
  always @(posedge clock) begin
    logic [9:0] ma;
    ma = bus.mem_addr[9:0];
    bus.mem_rdata <= {dmem[ma + 10'd3], dmem[ma + 10'd2],
                      dmem[ma + 10'd1], dmem[ma]};
    if (bus.mem_wenable) begin
      dmem[ma] = bus.mem_wdata[7:0];
      if (bus.mem_wwidth != write_byte)
        dmem[ma + 10'd1] = bus.mem_wdata[15:8];
      if (bus.mem_wwidth == write_word) begin
        dmem[ma + 10'd2] = bus.mem_wdata[23:16];
        dmem[ma + 10'd3] = bus.mem_wdata[31:24];
      end
    end
  end

  function automatic exp_t model(bit st, logic [2:0] f3,
                                 logic [31:0] addr,
                                 logic [31:0] wd);
    exp_t        e;
    int unsigned sz;
    logic [31:0] v;
    e.fault  = 2'd0;
    e.rdata  = '0;
    e.commit = 0;
    sz = 1 << f3[1:0];
    if (f3 == 3'd3 || f3 >= 3'd6 || (st && f3[2]))
      e.fault = 2'd3;
    else if (addr % sz != 0)
      e.fault = 2'd1;
    else if (64'(addr) + 64'(sz) - 64'd1 >= 64'd1024)
      e.fault = 2'd2;
    if (e.fault != 2'd0) begin
      e.lat = 1;
    end else if (st) begin
      e.lat = 2;
      e.commit = 1;
      for (int i = 0; i < int'(sz); i++)
        ref_mem[addr[9:0] + 10'(i)] = wd[8*i +: 8];
    end else begin
      e.lat = 3;
      v = '0;
      for (int i = 0; i < int'(sz); i++)
        v[8*i +: 8] = ref_mem[addr[9:0] + 10'(i)];
      if (!f3[2] && sz < 4 && v[8*sz-1])
        v = v | ~((32'd1 << (8*sz)) - 32'd1);
      e.rdata = v;
    end
    return e;
  endfunction

  // Compare process: inputs move at posedge+1, outputs sampled here.
  always @(negedge clock) begin
    bit ev;
    if (hs_pend) begin
      busy = 0;
      hs_pend = 0;
    end
    if (chk_on) begin
      if (busy) begin
        n++;
        ev = (n >= cur.lat);
        chk("req_ready_busy", 32'(bus.req_ready), 0);
        chk("resp_valid", 32'(bus.resp_valid), 32'(ev));
        chk("mem_wenable", 32'(bus.mem_wenable),
            32'(cur.commit && n == 1));
        if (ev) begin
          rv_cycles++;
          chk("resp_rdata", bus.resp_rdata, cur.rdata);
          chk("resp_fault", 32'(bus.resp_fault),
              32'(cur.fault));
          if (bus.resp_valid && bus.resp_ready) begin
            last_rdata = bus.resp_rdata;
            last_fault = bus.resp_fault;
            hs_pend = 1;
          end
        end
      end else begin
        chk("req_ready_idle", 32'(bus.req_ready), 1);
        chk("resp_valid_idle", 32'(bus.resp_valid), 0);
        chk("wenable_idle", 32'(bus.mem_wenable), 0);
      end
    end
  end

  task automatic do_req(bit st, logic [2:0] f3,
                        logic [31:0] addr, logic [31:0] wd,
                        int hold);
    exp_t e;
    e = model(st, f3, addr, wd);
    @(posedge clock); #1;
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.resp_ready = (hold == 0);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    cur = e;
    n = 0;
    rv_cycles = 0;
    busy = 1;
    for (int k = 0; k < 60 && busy; k++) begin
      @(posedge clock); #1;
      if (rv_cycles >= hold) bus.resp_ready = 1'b1;
    end
    chk("resp_timeout", 32'(busy), 0);
    busy = 0;
  endtask

  task automatic ld(logic [2:0] f3, logic [31:0] addr,
                    logic [31:0] want, string nm);
    do_req(1'b0, f3, addr, '0, 0);
    chk(nm, last_rdata, want);
  endtask

  task automatic flt(bit st, logic [2:0] f3,
                     logic [31:0] addr, logic [1:0] want,
                     string nm);
    do_req(st, f3, addr, 32'hDEAD_BEEF, 0);
    chk(nm, 32'(last_fault), 32'(want));
  endtask

  initial begin
    logic [31:0] ra;
    int          sel;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    chk("rst_fault", 32'(bus.resp_fault), 0);
    chk("rst_wenable", 32'(bus.mem_wenable), 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_wwidth", 32'(bus.mem_wwidth),
        32'(write_word));
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk_on = 1;

    do_req(1'b1, 3'b010, 32'h10, 32'h8765_4321, 0);
    ld(3'b010, 32'h10, 32'h8765_4321, "lw_first");
    do_req(1'b1, 3'b001, 32'h12, 32'h0000_FEDC, 0);
    ld(3'b010, 32'h10, 32'hFEDC_4321, "lw_after_sh");
    do_req(1'b1, 3'b000, 32'h11, 32'h0000_00BA, 0);
    ld(3'b010, 32'h10, 32'hFEDC_BA21, "lw_after_sb");
    ld(3'b000, 32'h11, 32'hFFFF_FFBA, "lb");
    ld(3'b100, 32'h11, 32'h0000_00BA, "lbu");
    ld(3'b001, 32'h12, 32'hFFFF_FEDC, "lh");
    ld(3'b101, 32'h12, 32'h0000_FEDC, "lhu");

    flt(1'b0, 3'b010, 32'h11, 2'b01, "lw_misalign");
    flt(1'b0, 3'b001, 32'h3FF, 2'b01, "lh_misalign");
    flt(1'b1, 3'b010, 32'h400, 2'b10, "sw_range");
    flt(1'b0, 3'b010, 32'hFFFF_FFFC, 2'b10, "lw_wrap");
    flt(1'b0, 3'b011, 32'h10, 2'b11, "f3_011");
    flt(1'b1, 3'b100, 32'h10, 2'b11, "store_bu");
    chk("word10_kept",
        {dmem[19], dmem[18], dmem[17], dmem[16]},
        32'hFEDC_BA21);

    do_req(1'b0, 3'b010, 32'h10, '0, 5);
    chk("lw_held", last_rdata, 32'hFEDC_BA21);

    do_req(1'b1, 3'b010, 32'h20, 32'hA5A5_A5A5, 0);
    @(posedge clock); #1;
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h1111_1111;
    @(posedge clock); #1;
    chk_on = 0;
    bus.req_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    chk("rst_access_wen", 32'(bus.mem_wenable), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_abort_ready", 32'(bus.req_ready), 1);
    chk("rst_abort_valid", 32'(bus.resp_valid), 0);
    chk_on = 1;
    ld(3'b010, 32'h20, 32'hA5A5_A5A5, "lw_after_abort");

    for (int t = 0; t < 250; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      ra = 32'($urandom_range(0, 63));
      else if (sel < 9) ra = 32'($urandom_range(1000, 1023));
      else              ra = $urandom;
      do_req(1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), ra, $urandom,
             $urandom_range(0, 2));
    end

    @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the hart's execute stage and the byte-enabled data `memory` block. Accepts one load or store request at a time from the core over a valid/ready handshake and checks it for legality, alignment and range. Drives the memory port and returns sign- or zero-extended load data, or a fault, through a held response handshake. It is the only master of the data memory port.

## Interface
- `XLEN`, 32 (from `isa_types`): data/address width.
- `MEM_BYTES`, 1024: size of the data memory in bytes; addresses `>= MEM_BYTES` fault.
- `clock`  in  1  rising-edge clock shared with `memory`.
- `reset_n`  in  1  reset; **synchronous, active-low**.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
- `req_addr`  in  XLEN  byte address.
- `req_wdata`  in  XLEN  store data, right-aligned (unshifted).
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  core accepts response.
- `resp_rdata`  out  XLEN  extended load data; 0 for stores and faults.
- `resp_fault`  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.
- `mem_addr`  out  XLEN  to `memory.addr`.
- `mem_wwidth`  out  `write_width_t`  to `memory.wwidth`.
- `mem_wenable`  out  1  to `memory.wenable`.
- `mem_wdata`  out  XLEN  to `memory.wdata`, unshifted (memory does lane shifting).
- `mem_rdata`  in  XLEN  from `memory.rdata`, already right-shifted by byte offset, valid the cycle after the address is presented.

## Operation
- States: IDLE, ACCESS, LOAD_CAPTURE, RESP.
- IDLE: `req_ready`=1. On `req_valid`: register store flag, funct3, address and data. Then classify in this priority order:
  - Illegal funct3 (011/11x, or store with bit2 set) → 11.
  - Misaligned (H with addr[0]≠0; W with addr[1:0]≠0) → 01.
  - Out of range: `addr + size - 1 >= MEM_BYTES`, computed in XLEN+1 bits so wrap-around faults → 10.
  - Fault → RESP with `resp_fault` set, no memory access. Otherwise → ACCESS.
- ACCESS: drive `mem_addr`, `mem_wwidth` (B→write_byte, H→write_halfword, W→write_word), `mem_wdata` from registers.
  - Store: `mem_wenable`=1 for exactly this cycle; next state RESP.
  - Load: `mem_wenable`=0; next state LOAD_CAPTURE.
- LOAD_CAPTURE: hold `mem_addr`. Extend `mem_rdata`:
  - B: sign-extend [7:0]; BU: zero-extend [7:0].
  - H: sign-extend [15:0]; HU: zero-extend [15:0].
  - W: pass through.
  - Register into `resp_rdata`; next state RESP.
- RESP: `resp_valid`=1, `resp_rdata`/`resp_fault` held stable until `resp_valid && resp_ready`; then IDLE. No new request is accepted in the same cycle as the response handshake.
- `mem_wenable` is 0 in every state other than ACCESS-with-store. It is gated by `reset_n`, so a store in ACCESS during reset does not commit.
- Outside ACCESS/LOAD_CAPTURE, `mem_addr`/`mem_wdata` hold their last values. `mem_wwidth` is don't-care unless `mem_wenable`=1.

## Timing
- Reset (clock edge with `reset_n`=0): state IDLE. `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_fault`=00, `mem_wenable`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wwidth`=write_word.
- Reset mid-operation from any state: abandon request; no response issued.
- Latency from accept edge (cycle 0) to first `resp_valid`:
  - Fault: cycle 1.
  - Store: cycle 2 (write commits at end of cycle 1).
  - Load: cycle 3.
- Throughput with `resp_ready` tied high:
  - Store: one per 3 cycles.
  - Load: one per 4 cycles.
  - Fault: one per 2 cycles.
- `resp_ready` low: RESP held indefinitely with outputs unchanged; `req_ready` stays 0.

## Test plan
- SW 0x87654321 @0x10, then LW @0x10 → `mem_wenable` high exactly in cycle 1 of the store; load `resp_rdata`=0x87654321, fault 00, `resp_valid` in cycle 3.
- SH 0xFEDC @0x12, then LW @0x10 → 0xFEDC4321. SB 0xBA @0x11, then LW @0x10 → 0xFEDCBA21.
- After the SB: LB @0x11 → 0xFFFFFFBA; LBU @0x11 → 0x000000BA; LH @0x12 → 0xFFFFFEDC; LHU @0x12 → 0x0000FEDC.
- LW @0x11 → fault 01; LH @0x3FF → fault 01. SW @0x400 → fault 10. LW @0xFFFFFFFC → fault 10. funct3 011 → fault 11. All respond in cycle 1 with `mem_wenable` never high; memory word @0x10 unchanged.
- LW with `resp_ready` held low 5 cycles → `resp_valid` and data stable throughout, `req_ready`=0. Release → handshake, then IDLE the following cycle.
- SW 0x11111111 @0x20 with `reset_n` low during ACCESS → `mem_wenable`=0, no response, state IDLE. Subsequent LW @0x20 returns prior contents.
